// File: rtl/reg_shift_sequencer_pkg.sv
// Shared types for the register-specified shift sequencer: shift-type codes,
// FSM state codes and the effective-shift-count rule.
package reg_shift_sequencer_pkg;

  localparam int REGISTER_LEN = 32;

  typedef enum logic [1:0] {
    LSL_SHIFT_STATE = 2'd0,
    LSR_SHIFT_STATE = 2'd1,
    ASR_SHIFT_STATE = 2'd2,
    ROR_SHIFT_STATE = 2'd3
  } shift_type_e;

  typedef enum logic [1:0] {
    RSS_IDLE  = 2'd0,
    RSS_SHIFT = 2'd1,
    RSS_DONE  = 2'd2
  } rss_state_e;

  // Steps needed for amount a. LSL/LSR go one past the word so the carry
  // clears; ROR reduces mod 32, with a nonzero multiple of 32 taking no steps.
  function automatic logic [5:0] eff_count(input logic [7:0] a, input shift_type_e t);
    logic [5:0] e;
    case (t)
      LSL_SHIFT_STATE, LSR_SHIFT_STATE: e = (a > 8'd33) ? 6'd33 : a[5:0];
      ASR_SHIFT_STATE:                  e = (a > 8'd32) ? 6'd32 : a[5:0];
      default:                          e = {1'b0, a[4:0]};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/reg_shift_sequencer_step.sv
// One partial shift of k bits (k >= 1) with ARM semantics: returns the shifted
// value and the last bit shifted out.
module shift_step_unit
  import reg_shift_sequencer_pkg::*;
#(
  parameter int K_W = 3
) (
  input  logic [REGISTER_LEN-1:0] v_i,
  input  shift_type_e             type_i,
  input  logic [K_W-1:0]          k_i,
  output logic [REGISTER_LEN-1:0] v_o,
  output logic                    c_o
);

  logic [32:0]        lsl_w;
  logic [32:0]        lsr_w;
  logic signed [32:0] asr_w;
  logic [63:0]        ror_w;

  // Shifting through an extra bit captures the carry in the same operation.
  assign lsl_w = {1'b0, v_i} << k_i;
  assign lsr_w = {v_i, 1'b0} >> k_i;
  assign asr_w = $signed({v_i, 1'b0}) >>> k_i;
  assign ror_w = {v_i, v_i} >> k_i;

  always_comb begin
    v_o = v_i;
    c_o = 1'b0;
    case (type_i)
      LSL_SHIFT_STATE: begin v_o = lsl_w[31:0];  c_o = lsl_w[32]; end
      LSR_SHIFT_STATE: begin v_o = lsr_w[32:1];  c_o = lsr_w[0];  end
      ASR_SHIFT_STATE: begin v_o = asr_w[32:1];  c_o = asr_w[0];  end
      default:         begin v_o = ror_w[31:0];  c_o = ror_w[31]; end
    endcase
  end

endmodule

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle shifter for register-specified shift amounts; shifts Rm up to
// STEP bits per cycle and stalls the pipeline until val2/carry are ready.
module reg_shift_sequencer
  import reg_shift_sequencer_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  logic [REGISTER_LEN-1:0] Rm,
  input  logic [REGISTER_LEN-1:0] Rs,
  input  logic [1:0]              shift_type,
  input  logic                    carry_in,
  output logic                    busy,
  output logic                    stall,
  output logic                    done,
  output logic [REGISTER_LEN-1:0] val2_out,
  output logic                    carry_out
);

  localparam int K_W = $clog2(STEP) + 1;

  rss_state_e              state_q, state_d;
  shift_type_e             type_q, type_d;
  logic [5:0]              rem_q, rem_d;
  logic [REGISTER_LEN-1:0] val_q, val_d;
  logic [REGISTER_LEN-1:0] val2_q, val2_d;
  logic                    carry_q, carry_d;

  logic [7:0]              amt;
  logic [5:0]              eff;
  logic [K_W-1:0]          k;
  logic                    last_step;
  logic [REGISTER_LEN-1:0] step_v;
  logic                    step_c;

  assign amt       = Rs[7:0];
  assign eff       = eff_count(amt, shift_type_e'(shift_type));
  assign last_step = (rem_q <= 6'(STEP));
  assign k         = last_step ? rem_q[K_W-1:0] : K_W'(STEP);

  shift_step_unit #(.K_W(K_W)) u_step (
    .v_i    (val_q),
    .type_i (type_q),
    .k_i    (k),
    .v_o    (step_v),
    .c_o    (step_c)
  );

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    rem_d   = rem_q;
    val_d   = val_q;
    val2_d  = val2_q;
    carry_d = carry_q;
    stall   = 1'b0;
    case (state_q)
      RSS_IDLE: begin
        stall = start && (eff != 6'd0);
        if (start && !flush) begin
          val_d  = Rm;
          type_d = shift_type_e'(shift_type);
          rem_d  = eff;
          if (eff != 6'd0) begin
            state_d = RSS_SHIFT;
          end else begin
            // Zero amount passes carry_in; a nonzero multiple-of-32 rotate gives Rm[31].
            state_d = RSS_DONE;
            val2_d  = Rm;
            carry_d = (amt == 8'd0) ? carry_in : Rm[31];
          end
        end
      end
      RSS_SHIFT: begin
        stall = 1'b1;
        val_d = step_v;
        rem_d = rem_q - 6'(k);
        if (last_step) begin
          state_d = RSS_DONE;
          val2_d  = step_v;
          carry_d = step_c;
        end
      end
      RSS_DONE: state_d = RSS_IDLE;
      default:  state_d = RSS_IDLE;
    endcase
    if (flush) begin
      state_d = RSS_IDLE;
      val2_d  = val2_q;
      carry_d = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RSS_IDLE;
      type_q  <= LSL_SHIFT_STATE;
      rem_q   <= '0;
      val_q   <= '0;
      val2_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      val2_q  <= val2_d;
      carry_q <= carry_d;
    end
  end

  assign busy      = (state_q != RSS_IDLE);
  assign done      = (state_q == RSS_DONE);
  assign val2_out  = val2_q;
  assign carry_out = carry_q;

endmodule
